// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the line-wide data memory responder.
//   LINE_W       default line width in bits (matches the data cache line)
//   OFFSET_BITS  byte-offset bits inside a line (32-byte lines)
//   LINE_ADDR_W  width of the line address carried in a captured request
//   state_e      responder FSM states
//   req_t        request captured at the IDLE edge
package dmem_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;
  localparam int LINE_ADDR_W = 32 - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] index;
    logic                   write;
    logic [LINE_W-1:0]      data;
  } req_t;

endpackage

// File: rtl/dmem_line_array.sv
// dmem_line_array: DEPTH x LINE_W single-port line storage.
//   clk_i    system clock
//   rst_i    synchronous active-low reset; clears only the read register
//   we_i     write enable (full line)
//   re_i     read enable; the read register updates only on a read
//   index_i  line index
//   wdata_i  write line data
//   rdata_o  registered read data; holds until the next read
module dmem_line_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  // Storage is deliberately not reset; contents survive a controller reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[index_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[index_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: responder end of the data-cache-to-memory interface.
// Captures a line request, waits a fixed latency, commits the access to the
// line array and pulses ack_o for one cycle.
//   clk_i        system clock
//   rst_i        synchronous active-low reset
//   addr_i       byte address; line index = addr_i[5 +: log2(DEPTH)]
//   data_i       write line data
//   enable_i     request valid, held until ack
//   write_i      1 = write line, 0 = read line
//   ack_o        one-cycle completion pulse
//   data_o       last read line, stable until the next read commits
//   proto_err_o  sticky protocol-error flag
// Optional feature macro: DMEM_PROTO_CHECK_EN enables the protocol checker
// driving proto_err_o; without it proto_err_o is tied 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for enable_i; captures the request when it is seen
// WAIT  | latency down-counter running; inputs ignored
// ACK   | access committed, ack_o high; enable_i ignored for this edge
module dmem_line_responder #(
  parameter int LINE_W  = dmem_pkg::LINE_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              proto_err_o
);

  import dmem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  // Sample edge plus the ACK-entry edge account for two of the LATENCY edges.
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, live_req, cur_req;
  logic             capture;
  logic             commit;
  logic             unused_addr_bits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          capture = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      req_q <= live_req;
    end
  end

  always_comb begin
    live_req.index = addr_i[31:OFFSET_BITS];
    live_req.write = write_i;
    live_req.data  = data_i;
  end

  // With LATENCY=1 the commit happens on the capture edge itself, so the
  // array must see the live inputs rather than the not-yet-loaded register.
  assign cur_req = capture ? live_req : req_q;

  // Gating with rst_i makes a reset edge discard a pending write.
  assign commit = rst_i && (state_d == ACK) && (state_q != ACK);

  dmem_line_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (commit & cur_req.write),
    .re_i    (commit & ~cur_req.write),
    .index_i (cur_req.index[IDX_W-1:0]),
    .wdata_i (cur_req.data),
    .rdata_o (data_o)
  );

  assign ack_o = (state_q == ACK);

  // Upper address bits alias onto the same lines; offset bits are don't-care.
  assign unused_addr_bits = ^{addr_i[OFFSET_BITS-1:0], req_q.index[LINE_ADDR_W-1:IDX_W]};

`ifdef DMEM_PROTO_CHECK_EN
  logic proto_err_q;
  logic proto_viol;

  always_comb begin
    proto_viol = (state_q == WAIT) &&
                 (!enable_i ||
                  (addr_i[OFFSET_BITS +: IDX_W] != req_q.index[IDX_W-1:0]) ||
                  (write_i != req_q.write) ||
                  (req_q.write && (data_i != req_q.data)));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      proto_err_q <= 1'b0;
    end else if (proto_viol) begin
      proto_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && proto_viol && !proto_err_q) begin
      $error("dmem_line_responder: request changed or dropped while waiting");
    end
  end

  assign proto_err_o = proto_err_q;
`else
  assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

  localparam int LW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   addr_i;
  logic [LW-1:0] data_i;
  logic          enable_i;
  logic          write_i;
  logic          ack_o;
  logic [LW-1:0] data_o;
  logic          proto_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [LW-1:0] D_A = {8{32'hA5A5_0003}};
  localparam logic [LW-1:0] D_B = {8{32'h3939_0027}};
  localparam logic [LW-1:0] D_C = {8{32'h0707_C0DE}};
  localparam logic [LW-1:0] D_D = {8{32'hD00D_0201}};
  localparam logic [LW-1:0] D_E = {8{32'h5555_0005}};
  localparam logic [LW-1:0] D_F = {8{32'hFFFF_0005}};
  localparam logic [LW-1:0] D_G = {8{32'h0909_1234}};

`ifdef DMEM_PROTO_CHECK_EN
  localparam int PERR_FIRST = 4;
  localparam logic PERR_HELD = 1'b1;
`else
  localparam int PERR_FIRST = 0;
  localparam logic PERR_HELD = 1'b0;
`endif

  dmem_line_responder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .enable_i    (enable_i),
    .write_i     (write_i),
    .ack_o       (ack_o),
    .data_o      (data_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request and counts edges until ack_o is seen (40 = timeout).
  task automatic run_req(input logic wr, input logic [31:0] addr,
                         input logic [LW-1:0] d, output int lat);
    write_i  = wr;
    addr_i   = addr;
    data_i   = d;
    enable_i = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (ack_o) break;
    end
  endtask

  task automatic finish_req(input string tag);
    enable_i = 1'b0;
    tick();
    check(tag, LW'(ack_o), LW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, acks, perr_first;

    rst_i    = 1'b0;
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = 32'h0;
    data_i   = '0;
    repeat (3) tick();
    check("rst_ack",  LW'(ack_o), LW'(0));
    check("rst_data", data_o, '0);
    check("rst_perr", LW'(proto_err_o), LW'(0));

    rst_i = 1'b1;
    run_req(1'b0, 32'h0, '0, lat);
    check("rst_release_lat", LW'(lat), LW'(10));
    finish_req("rst_release_ack_pulse");

    run_req(1'b1, 32'h0000_0060, D_A, lat);
    check("wr3_lat", LW'(lat), LW'(10));
    finish_req("wr3_ack_pulse");
    run_req(1'b0, 32'h0000_0060, '0, lat);
    check("rd3_lat", LW'(lat), LW'(10));
    check("rd3_data", data_o, D_A);
    finish_req("rd3_ack_pulse");
    repeat (4) tick();
    check("rd3_hold", data_o, D_A);

    run_req(1'b1, 32'h0000_04E0, D_B, lat);
    finish_req("wr39_ack_pulse");

    run_req(1'b1, 32'h0000_00E0, D_C, lat);
    check("wb7_lat", LW'(lat), LW'(10));
    check("wb7_data_o_unchanged", data_o, D_A);
    run_req(1'b0, 32'h0000_04E0, '0, lat2);
    check("refill39_spacing", LW'(lat2), LW'(11));
    check("refill39_data", data_o, D_B);
    finish_req("refill39_ack_pulse");

    run_req(1'b0, 32'h0000_00E0, '0, lat);
    check("rd7_data", data_o, D_C);
    finish_req("rd7_ack_pulse");

    run_req(1'b1, 32'h0000_4020, D_D, lat);
    finish_req("wrap_wr_ack_pulse");
    run_req(1'b0, 32'h0000_0020, '0, lat);
    check("wrap_rd_data", data_o, D_D);
    finish_req("wrap_rd_ack_pulse");

    run_req(1'b1, 32'h0000_00A0, D_E, lat);
    finish_req("wr5_old_ack_pulse");
    write_i  = 1'b1;
    addr_i   = 32'h0000_00A0;
    data_i   = D_F;
    enable_i = 1'b1;
    tick();
    repeat (4) tick();
    check("midrst_no_ack_before", LW'(ack_o), LW'(0));
    rst_i    = 1'b0;
    enable_i = 1'b0;
    acks = 0;
    repeat (2) begin
      tick();
      if (ack_o) acks++;
    end
    check("midrst_data_cleared", data_o, '0);
    rst_i = 1'b1;
    repeat (15) begin
      tick();
      if (ack_o) acks++;
    end
    check("midrst_no_ack", LW'(acks), LW'(0));
    run_req(1'b0, 32'h0000_00A0, '0, lat);
    check("midrst_rd5_lat", LW'(lat), LW'(10));
    check("midrst_rd5_old_data", data_o, D_E);
    finish_req("midrst_rd5_ack_pulse");

    // enable_i dropped during WAIT: request must still complete on time.
    write_i    = 1'b1;
    addr_i     = 32'h0000_0120;
    data_i     = D_G;
    enable_i   = 1'b1;
    lat        = 0;
    perr_first = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (proto_err_o && perr_first == 0) perr_first = lat;
      if (lat == 3) enable_i = 1'b0;
      if (ack_o) break;
    end
    check("drop_en_ack_lat", LW'(lat), LW'(10));
    check("drop_en_perr_first", LW'(perr_first), LW'(PERR_FIRST));
    tick();
    check("drop_en_ack_pulse", LW'(ack_o), LW'(0));
    check("drop_en_perr_held", LW'(proto_err_o), LW'(PERR_HELD));
    run_req(1'b0, 32'h0000_0120, '0, lat);
    check("drop_en_rd9_data", data_o, D_G);
    finish_req("drop_en_rd9_ack_pulse");
    check("drop_en_perr_still", LW'(proto_err_o), LW'(PERR_HELD));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
